// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage with one-entry hold buffer and branch redirect
// Optional perf counters (stall_cycles, flush_count) enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_incr_out,
  output logic [31:0] instr_out,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        out_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] pc_next_seq;
  logic [31:0] target_aligned;
  logic [31:0] buf_instr, buf_instr_d;
  logic [31:0] buf_pc_incr, buf_pc_incr_d;
  logic [31:0] instr_d, pc_incr_d;
  logic        valid_d;
  logic        accept;

  assign imem_req       = (state == FETCH);
  assign imem_addr      = pc;
  assign pc_next_seq    = pc + STEP;
  assign target_aligned = branch_target & ~32'h3;
  assign accept         = !stall || !out_valid;

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    buf_instr_d   = buf_instr;
    buf_pc_incr_d = buf_pc_incr;
    instr_d       = instr_out;
    pc_incr_d     = pc_incr_out;
    valid_d       = out_valid;

    // Redirect wins over everything, including a response landing on the same edge.
    if (branch_taken) begin
      pc_d          = target_aligned;
      state_d       = FETCH;
      valid_d       = 1'b0;
      instr_d       = '0;
      pc_incr_d     = '0;
      buf_instr_d   = '0;
      buf_pc_incr_d = '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_next_seq;
            if (accept) begin
              instr_d   = imem_rdata;
              pc_incr_d = pc_next_seq;
              valid_d   = 1'b1;
            end else begin
              buf_instr_d   = imem_rdata;
              buf_pc_incr_d = pc_next_seq;
              state_d       = HOLD;
            end
          end else if (!stall) begin
            valid_d   = 1'b0;
            instr_d   = '0;
            pc_incr_d = '0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d   = buf_instr;
            pc_incr_d = buf_pc_incr;
            valid_d   = 1'b1;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      buf_instr   <= '0;
      buf_pc_incr <= '0;
      instr_out   <= '0;
      pc_incr_out <= '0;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      buf_instr   <= buf_instr_d;
      buf_pc_incr <= buf_pc_incr_d;
      instr_out   <= instr_d;
      pc_incr_out <= pc_incr_d;
      out_valid   <= valid_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && out_valid) stall_cycles <= stall_cycles + 32'd1;
      if (branch_taken)       flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_incr_out;
  logic [31:0] instr_out;
  logic        out_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] pci;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc_incr_out  (pc_incr_out),
    .instr_out    (instr_out),
`ifdef IF_FETCH_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic v, input logic [31:0] pci, input logic [31:0] ins);
    exp_t e;
    e.tag = tag; e.v = v; e.pci = pci; e.ins = ins;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_valid"}, {31'd0, out_valid}, {31'd0, e.v});
      chk({e.tag, "_pc_incr"}, pc_incr_out, e.pci);
      chk({e.tag, "_instr"}, instr_out, e.ins);
    end
  endtask

  // One clock: drive inputs, check request side before the edge, then outputs after it.
  task automatic step(input string tag, input logic st, input logic br, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rd, input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] epci, input logic [31:0] eins);
    stall = st; branch_taken = br; branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
    #1;
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, ereq});
    chk({tag, "_addr"}, imem_addr, eaddr);
    push_exp(tag, ev, epci, eins);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    stall = 0; branch_taken = 0; branch_target = '0; imem_ready = 0; imem_rdata = '0;
    #1;
    push_exp(tag, 1'b0, 32'h0, 32'h0);
    pop_check();
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 0; stall = 0; branch_taken = 0; branch_target = '0; imem_ready = 0; imem_rdata = '0;
    #11;
    do_reset("rst0");

    step("seq0", 0, 0, 0, 1, 32'h11, 1, 32'h0, 1, 32'h4, 32'h11);
    step("seq1", 0, 0, 0, 1, 32'h22, 1, 32'h4, 1, 32'h8, 32'h22);
    step("seq2", 0, 0, 0, 1, 32'h33, 1, 32'h8, 1, 32'hC, 32'h33);

    do_reset("rst1");
    step("wt0", 0, 0, 0, 1, 32'h11, 1, 32'h0, 1, 32'h4, 32'h11);
    step("wt1", 0, 0, 0, 1, 32'h22, 1, 32'h4, 1, 32'h8, 32'h22);
    for (int i = 0; i < 3; i++)
      step("wait", 0, 0, 0, 0, 32'hDEAD, 1, 32'h8, 0, 32'h0, 32'h0);
    step("wt_rdy", 0, 0, 0, 1, 32'h44, 1, 32'h8, 1, 32'hC, 32'h44);

    do_reset("rst2");
    step("st0", 0, 0, 0, 1, 32'hA0, 1, 32'h0, 1, 32'h4, 32'hA0);
    step("st_resp", 1, 0, 0, 1, 32'hAB, 1, 32'h4, 1, 32'h4, 32'hA0);
    for (int i = 0; i < 3; i++)
      step("hold", 1, 0, 0, 1, 32'hFF, 0, 32'h8, 1, 32'h4, 32'hA0);
    step("unstall", 0, 0, 0, 1, 32'hFF, 0, 32'h8, 1, 32'h8, 32'hAB);
    step("resume", 0, 0, 0, 1, 32'hCD, 1, 32'h8, 1, 32'hC, 32'hCD);

    step("br_drop", 0, 1, 32'h103, 1, 32'hEE, 1, 32'hC, 0, 32'h0, 32'h0);
    step("br_tgt", 0, 0, 0, 1, 32'h55, 1, 32'h100, 1, 32'h104, 32'h55);

    step("br_wrap", 0, 1, 32'hFFFF_FFFE, 0, 32'h0, 1, 32'h104, 0, 32'h0, 32'h0);
    step("wrap", 0, 0, 0, 1, 32'h77, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h77);
    step("st_idle", 1, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0, 32'h77);
    step("br_stall", 1, 1, 32'h20, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0);

    step("pre_hold", 0, 0, 0, 1, 32'h99, 1, 32'h20, 1, 32'h24, 32'h99);
    step("to_hold", 1, 0, 0, 1, 32'h9A, 1, 32'h24, 1, 32'h24, 32'h99);
    step("in_hold", 1, 0, 0, 1, 32'h0, 0, 32'h28, 1, 32'h24, 32'h99);
    #2;
    reset = 1'b0;
    #1;
    push_exp("async_rst", 1'b0, 32'h0, 32'h0);
    pop_check();
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    step("post_rst", 0, 0, 0, 1, 32'h31, 1, 32'h0, 1, 32'h4, 32'h31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
